addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Round-robin arbiter that shares one `addsub16bit` instance among `NREQ` requesters inside the ALU.
- Each requester presents operands and an add/sub select under a valid/ready handshake.
- The arbiter grants at most one requester per cycle and drives the shared `addsub16bit` combinationally from the winner.
- It captures the sum/difference, a zero flag and the winner's index in a single-entry response register with backpressure.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, ≥2.
- `W`, 16: operand width. Fixed at 16 to match `addsub16bit`.
- `IDW`, 2: requester index width, `$clog2(NREQ)`.

Ports (clock and reset first):
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_in1`  in  NREQ*W  packed operand A, requester i at `[i*W +: W]`.
- `req_in2`  in  NREQ*W  packed operand B, same packing.
- `req_sub`  in  NREQ  1 = in1−in2, 0 = in1+in2.
- `req_ready`  out  NREQ  one-hot grant; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_data`  out  W  result, modulo 2^16.
- `rsp_zero`  out  1  `rsp_data == 0`.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `rsp_ready`  in  1  downstream accepts the response this cycle.

## Operation
- `can_issue = !rsp_valid || rsp_ready`.
- Priority pointer `ptr` (IDW bits): the search starts at `ptr` and wraps modulo NREQ. The first `i` with `req_valid[i]` is the winner.
- `req_ready[winner] = can_issue`; all other `req_ready` bits are 0. With no valid request, `req_ready` is all 0.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- The winner's `in1`, `in2` and `sub` are muxed into the shared `addsub16bit`. Result `s` = in1 + (sub ? ~in2 + 1 : in2), truncated to 16 bits; carry-out is discarded.
- On a transfer:
  - `rsp_data ← s`, `rsp_zero ← (s == 0)`, `rsp_id ← winner`, `rsp_valid ← 1`.
  - `ptr ← (winner + 1) mod NREQ`.
- With no transfer and `rsp_ready` high, `rsp_valid ← 0`. `ptr` is unchanged.
- With `rsp_valid && !rsp_ready`:
  - the response registers hold;
  - `req_ready` is all 0;
  - `ptr` holds.
- Requesters must hold `req_valid` and operands stable until granted. A request is never dropped.
- Fairness: a continuously valid requester is granted within NREQ issuing cycles.

## Timing
- Reset (async assert, sync deassert expected):
  - `rsp_valid`=0, `rsp_data`=0, `rsp_zero`=0, `rsp_id`=0, `ptr`=0.
  - `req_ready` is 0 while `rst_n` is low.
- Latency: the grant in cycle N gives a response visible in cycle N+1.
- Throughput: one operation per cycle while `rsp_ready` stays high.
- Simultaneous response drain and new grant in the same cycle: the register is overwritten with the new result and `rsp_valid` stays 1. No bubble.
- Reset asserted mid-operation:
  - any pending response is lost and `ptr` returns to 0;
  - requesters re-present their requests after reset.
- `ptr` wrap: after granting NREQ−1, `ptr` becomes 0.
- Overflow: 0xFFFF+1 → 0x0000 and `rsp_zero`=1. 0x0000−1 → 0xFFFF. No overflow flag is produced.

## Structure
- Shared package `alu_pkg`:
  - `ALU_W` = 16;
  - `ADDSUB_NREQ` default;
  - enum `addsub_op_e` {ADD=0, SUB=1};
  - packed struct `addsub_rsp_t` {data, zero, id}.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and `gnt_idx`. Purely combinational and reusable by other ALU resource arbiters.
- `addsub16bit` is instantiated unchanged, once.
- The top level holds `ptr`, the response register and the operand mux.

## Test plan
- Reset check: with `rst_n`=0 and all `req_valid`=1 → `req_ready`=0, `rsp_valid`=0; `ptr`=0 after release.
- Single request, add: `req_valid`=0001, in1=0x1234, in2=0x0F0F, sub=0, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_data`=0x2143, `rsp_id`=0, `rsp_zero`=0.
- Subtract and wrap: requester 2 presents 0x0000−0x0001 → `rsp_data`=0xFFFF. Requester 1 presents 0x8000−0x8000 → `rsp_data`=0, `rsp_zero`=1.
- Round-robin: all four valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0, one per cycle, each `req_ready` one-hot.
- Backpressure: `rsp_ready`=0 for 3 cycles with `rsp_valid`=1 → `rsp_data`/`rsp_id` hold, `req_ready`=0. Release → the held response transfers and the next grant issues in the same cycle.
- Mid-operation reset: assert `rst_n` low while `rsp_valid`=1 → outputs clear immediately. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, add/sub arbiter defaults, op encoding
// and the response record layout.
package alu_pkg;

    localparam int ALU_W       = 16;
    localparam int ADDSUB_NREQ = 4;
    localparam int ADDSUB_IDW  = $clog2(ADDSUB_NREQ);

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } addsub_op_e;

    // Result record produced by the shared adder.
    typedef struct packed {
        logic [ALU_W-1:0]      data;
        logic                  zero;
        logic [ADDSUB_IDW-1:0] id;
    } addsub_rsp_t;

    // Next round-robin pointer after granting idx among n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/addsub16bit.sv
// 16-bit adder/subtractor: s = a + b, or a - b (two's complement) when sub is set.
// Carry-out is not produced; results wrap modulo 2^16.
module addsub16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] s
);

    logic [15:0] b_eff;

    // Invert B and inject the +1 through the carry-in for subtraction.
    always_comb begin
        b_eff = b ^ {16{sub}};
        s     = a + b_eff + {15'b0, sub};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps modulo N;
// the first asserted req wins. gnt is one-hot and gated by en; gnt_idx always
// reports the winner (0 when nothing requests) so it can steer datapath muxes
// independently of en.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk the N positions from ptr; one extra bit on sum absorbs ptr+k before the wrap.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found && en)
            gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one addsub16bit among NREQ requesters. A round-robin winner is granted
// when the single-entry response register is empty or draining this cycle; its
// operands feed the adder combinationally and the result lands in the register
// on the same edge, so back-to-back grants run at one op per cycle.
module addsub_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = ADDSUB_NREQ,
    parameter int W    = ALU_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_in1,
    input  logic [NREQ*W-1:0] req_in2,
    input  logic [NREQ-1:0]   req_sub,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_zero,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready
);

    logic [NREQ-1:0][W-1:0] in1_arr;
    logic [NREQ-1:0][W-1:0] in2_arr;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win_idx;
    logic [NREQ-1:0] gnt;
    logic            can_issue;
    logic            arb_en;
    logic            xfer;

    logic [W-1:0]    mux_in1;
    logic [W-1:0]    mux_in2;
    addsub_op_e      mux_op;
    logic            mux_sub;
    logic [W-1:0]    sum;

    // Unpack the flat operand buses into per-requester lanes.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign in1_arr[i] = req_in1[i*W +: W];
        assign in2_arr[i] = req_in2[i*W +: W];
    end

    // Grants are suppressed while reset is held, even though the empty register
    // would otherwise allow an issue.
    assign can_issue = !rsp_valid || rsp_ready;
    assign arb_en    = can_issue && rst_n;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (win_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // Steer the winner's operands into the shared adder.
    always_comb begin
        mux_in1 = in1_arr[win_idx];
        mux_in2 = in2_arr[win_idx];
        mux_op  = addsub_op_e'(req_sub[win_idx]);
        mux_sub = (mux_op == SUB);
    end

    addsub16bit u_addsub (
        .a   (mux_in1),
        .b   (mux_in2),
        .sub (mux_sub),
        .s   (sum)
    );

    // Response register and priority pointer: load on transfer (overwriting a
    // draining entry), empty on drain without a new grant, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sum;
            rsp_zero  <= (sum == '0);
            rsp_id    <= win_idx;
            ptr       <= IDW'(rr_next(int'(win_idx), NREQ));
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a transaction-level reference model
// compared every cycle, plus literal expectations for the documented scenarios.
module tb_addsub_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_in1;
    logic [NREQ*W-1:0] req_in2;
    logic [NREQ-1:0]   req_sub;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              rsp_zero;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;

    int checks = 0;
    int errors = 0;

    addsub_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_sub   (req_sub),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_ptr;
    logic        m_valid;
    int          m_data;
    int          m_id;

    // First valid requester scanning from p with wrap; -1 when none.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int calc(input int a, input int b, input logic s);
        return s ? ((a - b) & 32'hFFFF) : ((a + b) & 32'hFFFF);
    endfunction

    int mw;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   <= 0;
            m_valid <= 1'b0;
            m_data  <= 0;
            m_id    <= 0;
        end else begin
            mw = pick(req_valid, m_ptr);
            if (mw >= 0 && (!m_valid || rsp_ready)) begin
                m_valid <= 1'b1;
                m_data  <= calc(int'(req_in1[mw*W +: W]), int'(req_in2[mw*W +: W]), req_sub[mw]);
                m_id    <= mw;
                m_ptr   <= (mw + 1) % NREQ;
            end else if (rsp_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    logic [NREQ-1:0] c_rdy;
    int              c_w;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
            c_rdy = '0;
            c_w   = pick(req_valid, m_ptr);
            if (c_w >= 0 && (!m_valid || rsp_ready)) c_rdy[c_w] = 1'b1;
            chk("model_req_ready", 32'(req_ready), 32'(c_rdy));
            chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_rsp_data", 32'(rsp_data), m_data);
                chk("model_rsp_zero", 32'(rsp_zero), 32'(m_data == 0));
                chk("model_rsp_id",   32'(rsp_id),   m_id);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
        req_in1[i*W +: W] = a;
        req_in2[i*W +: W] = b;
        req_sub[i]        = s;
    endtask

    task automatic expect_rsp(input string name, input logic [15:0] d, input logic z, input int id);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_data"},  32'(rsp_data),  32'(d));
        chk({name, "_zero"},  32'(rsp_zero),  32'(z));
        chk({name, "_id"},    32'(rsp_id),    id);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_in1   = '0;
        req_in2   = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;

        // Reset holds grants off even with every requester valid.
        cyc();
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        cyc();
        req_valid = '0;
        rst_n     = 1'b1;

        // Single add from requester 0.
        setreq(0, 16'h1234, 16'h0F0F, 1'b0);
        req_valid = 4'b0001;
        #1 chk("add_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        expect_rsp("add", 16'h2143, 1'b0, 0);

        // Drain with nothing pending empties the register.
        cyc();
        chk("drain_valid", 32'(rsp_valid), 32'd0);

        // Subtract wrap from requester 2 (ptr=1).
        setreq(2, 16'h0000, 16'h0001, 1'b1);
        req_valid = 4'b0100;
        cyc();
        req_valid = '0;
        expect_rsp("sub_wrap", 16'hFFFF, 1'b0, 2);

        // Equal operands subtract to zero, requester 1 via pointer wrap (ptr=3).
        setreq(1, 16'h8000, 16'h8000, 1'b1);
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        expect_rsp("sub_zero", 16'h0000, 1'b1, 1);

        // Add overflow from requester 0 (ptr=2).
        setreq(0, 16'hFFFF, 16'h0001, 1'b0);
        req_valid = 4'b0001;
        cyc();
        req_valid = '0;
        expect_rsp("add_ovf", 16'h0000, 1'b1, 0);

        // Requester 3 alone brings ptr back to 0 (ptr=1 search 1,2,3).
        setreq(3, 16'h0005, 16'h0003, 1'b0);
        req_valid = 4'b1000;
        cyc();
        req_valid = '0;
        expect_rsp("req3", 16'h0008, 1'b0, 3);

        // Round robin with all four continuously valid.
        setreq(0, 16'h0100, 16'h0000, 1'b0);
        setreq(1, 16'h0200, 16'h0001, 1'b1);
        setreq(2, 16'h0300, 16'h0002, 1'b0);
        setreq(3, 16'h0400, 16'h0003, 1'b1);
        req_valid = 4'b1111;
        cyc(); expect_rsp("rr0", 16'h0100, 1'b0, 0);
        cyc(); expect_rsp("rr1", 16'h01FF, 1'b0, 1);
        cyc(); expect_rsp("rr2", 16'h0302, 1'b0, 2);
        cyc(); expect_rsp("rr3", 16'h03FD, 1'b0, 3);
        cyc(); expect_rsp("rr4", 16'h0100, 1'b0, 0);

        // Backpressure for three cycles: response holds, no grants.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'd0);
            cyc();
            expect_rsp("bp_hold", 16'h0100, 1'b0, 0);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'b0010);
        cyc();
        expect_rsp("bp_next", 16'h01FF, 1'b0, 1);

        // Reset mid-operation clears outputs at once; ptr restarts at 0.
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_data",  32'(rsp_data),  32'd0);
        chk("midrst_id",    32'(rsp_id),    32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        #1 chk("postrst_ready", 32'(req_ready), 32'b0001);
        cyc();
        expect_rsp("postrst", 16'h0100, 1'b0, 0);

        req_valid = '0;
        cyc();
        chk("final_valid", 32'(rsp_valid), 32'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
